note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_pkg.sv | 28 ++
 rtl/note_sequencer_rom.sv | 45 ++++
 rtl/note_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared soundgen definitions: sequencer state encoding, ROM entry field
// widths, the end-of-melody marker and melody table selectors.
package note_sequencer_pkg;

    // Sequencer states; IDLE is the reset state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    // ROM entry is {period[N-1:0], dur[DUR_W-1:0]}; dur counts ticks.
    localparam int DUR_W = 4;

    // A duration of zero marks the end of the melody.
    localparam logic [DUR_W-1:0] DUR_END = '0;

    // Melody tables available in note_rom.
    localparam int MELODY_DEMO  = 0;
    localparam int MELODY_SCALE = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/note_sequencer_rom.sv
// Melody table: combinational lookup of {period, dur} by step index.
// Swapping melodies only touches this file (or the MELODY selector).
module note_rom
    import note_sequencer_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEPS  = 16,
    parameter int MELODY = MELODY_DEMO
) (
    input  logic [$clog2(STEPS)-1:0] idx,
    output logic [N-1:0]             period,
    output logic [DUR_W-1:0]         dur
);

    // Table lookup; unlisted demo entries read as end markers.
    always_comb begin
        period = '0;
        dur    = DUR_END;
        if (MELODY == MELODY_SCALE) begin
            // Rising scale, one tick per note, no end marker.
            period = N'(10 * (int'(idx) + 1));
            dur    = DUR_W'(1);
        end else begin
            case (int'(idx))
                0: begin
                    period = N'(100);
                    dur    = DUR_W'(2);
                end
                1: begin
                    period = '0;          // rest
                    dur    = DUR_W'(1);
                end
                2: begin
                    period = N'(50);
                    dur    = DUR_W'(3);
                end
                default: begin
                    period = '0;
                    dur    = DUR_END;
                end
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks the note ROM, holding each tone for dur ticks
// followed by a silent gap, and drives a tone/PWM generator.
//
// Output timing: every output is a register loaded from the state the FSM
// was in during the previous cycle, so outputs trail the state by one
// cycle. This puts note_strobe and the new tone_period in the cycle after
// edge k+2 when start is sampled at edge k. note_strobe is a one-cycle
// pulse that qualifies tone_period; the downstream generator has no
// back-pressure, so there is no ready signal. done pulses in the cycle
// the end-of-melody decision is taken; stop and reset never raise it.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int N         = 8,
    parameter int STEPS     = 16,
    parameter int TICK_DIV  = 12000,
    parameter int GAP_TICKS = 1,
    parameter int MELODY    = MELODY_DEMO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [N-1:0]             tone_period,
    output logic                     tone_en,
    output logic                     note_strobe,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     playing,
    output logic                     done,
    output seq_state_t               dbg_state
);

    localparam int SW = $clog2(STEPS);
    localparam int TW = cnt_width(TICK_DIV);
    localparam int NW = cnt_width((GAP_TICKS > 16) ? GAP_TICKS : 16);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [NW-1:0] GAP_LAST  = NW'(GAP_TICKS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    seq_state_t       state;
    logic [SW-1:0]    step_q;
    logic [N-1:0]     period_q;
    logic [DUR_W-1:0] dur_q;
    logic [TW-1:0]    tick_cnt;   // clk cycles within the current tick
    logic [NW-1:0]    tick_num;   // ticks elapsed in the current PLAY/GAP

    logic [N-1:0]     rom_period;
    logic [DUR_W-1:0] rom_dur;

    note_rom #(
        .N      (N),
        .STEPS  (STEPS),
        .MELODY (MELODY)
    ) u_rom (
        .idx    (step_q),
        .period (rom_period),
        .dur    (rom_dur)
    );

    assign dbg_state = state;

    // Sequencer FSM with its tick/duration counters and registered outputs.
    always_ff @(posedge clk) begin
        note_strobe <= 1'b0;
        done        <= 1'b0;
        if (reset) begin
            state       <= ST_IDLE;
            step_q      <= '0;
            period_q    <= '0;
            dur_q       <= '0;
            tick_cnt    <= '0;
            tick_num    <= '0;
            tone_period <= '0;
            tone_en     <= 1'b0;
            step_idx    <= '0;
            playing     <= 1'b0;
        end else if (stop) begin
            // Abort: outputs clear together with the state, no done pulse.
            state       <= ST_IDLE;
            step_q      <= '0;
            period_q    <= '0;
            dur_q       <= '0;
            tick_cnt    <= '0;
            tick_num    <= '0;
            tone_period <= '0;
            tone_en     <= 1'b0;
            step_idx    <= '0;
            playing     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tone_period <= '0;
                    tone_en     <= 1'b0;
                    step_idx    <= '0;
                    playing     <= 1'b0;
                    step_q      <= '0;
                    if (start) begin
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // tone_period keeps the previous note's value here.
                    tone_en  <= 1'b0;
                    step_idx <= step_q;
                    playing  <= 1'b1;
                    if (rom_dur == DUR_END) begin
                        step_q <= '0;
                        if (!loop_en) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        period_q <= rom_period;
                        dur_q    <= rom_dur;
                        tick_cnt <= '0;
                        tick_num <= '0;
                        state    <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    tone_period <= period_q;
                    tone_en     <= (period_q != '0);
                    step_idx    <= step_q;
                    playing     <= 1'b1;
                    // Counters are both zero only in the first PLAY cycle.
                    note_strobe <= (tick_cnt == '0) && (tick_num == '0);
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (tick_num == NW'(dur_q - DUR_W'(1))) begin
                            tick_num <= '0;
                            state    <= ST_GAP;
                        end else begin
                            tick_num <= tick_num + NW'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end

                ST_GAP: begin
                    tone_en  <= 1'b0;
                    step_idx <= step_q;
                    playing  <= 1'b1;
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (tick_num == GAP_LAST) begin
                            tick_num <= '0;
                            if (step_q == STEP_LAST) begin
                                // Ran off the end of the table without a marker.
                                step_q <= '0;
                                if (loop_en) begin
                                    state <= ST_LOAD;
                                end else begin
                                    state <= ST_IDLE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                step_q <= step_q + SW'(1);
                                state  <= ST_LOAD;
                            end
                        end else begin
                            tick_num <= tick_num + NW'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: the demo melody on a 16-step instance and the
// end-of-table path on a 4-step scale instance, both at TICK_DIV=4,
// GAP_TICKS=1. Expected note/done events go into a queue when stimulus is
// issued; a negedge monitor pops and compares them as the DUT emits them.
module tb_note_sequencer;
    import note_sequencer_pkg::*;

    localparam int TD = 4;
    localparam int GT = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
    logic       start_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
    logic [7:0] tone_period_a, tone_period_b;
    logic       tone_en_a, note_strobe_a, playing_a, done_a;
    logic       tone_en_b, note_strobe_b, playing_b, done_b;
    logic [3:0] step_idx_a;
    logic [1:0] step_idx_b;
    seq_state_t dbg_a, dbg_b;

    note_sequencer #(
        .N(8), .STEPS(16), .TICK_DIV(TD), .GAP_TICKS(GT), .MELODY(MELODY_DEMO)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .loop_en(loop_a),
        .tone_period(tone_period_a), .tone_en(tone_en_a), .note_strobe(note_strobe_a),
        .step_idx(step_idx_a), .playing(playing_a), .done(done_a), .dbg_state(dbg_a)
    );

    note_sequencer #(
        .N(8), .STEPS(4), .TICK_DIV(TD), .GAP_TICKS(GT), .MELODY(MELODY_SCALE)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .loop_en(loop_b),
        .tone_period(tone_period_b), .tone_en(tone_en_b), .note_strobe(note_strobe_b),
        .step_idx(step_idx_b), .playing(playing_b), .done(done_b), .dbg_state(dbg_b)
    );

    // ---------------- scoreboard ----------------
    // kind 0 = note_strobe event, kind 1 = done pulse. 'at' is the cyc value
    // seen at the negedge of the event cycle; 'hi' is the number of tone_en
    // high cycles since the previous event of that unit.
    typedef struct {
        int unit;
        int kind;
        int at;
        int period;
        int step;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int unit, input int kind, input int at,
                                 input int period, input int step, input int hi);
        exp_t e;
        e.unit   = unit;
        e.kind   = kind;
        e.at     = at;
        e.period = period;
        e.step   = step;
        e.hi     = hi;
        exp_q.push_back(e);
    endfunction

    // Demo melody notes for a start sampled at edge k. Strobe spacing is
    // dur*TD + GT*TD + 1 (PLAY, GAP, one LOAD cycle).
    function automatic void push_demo(input int k);
        push(0, 0, k + 2,  100, 0, 0);
        push(0, 0, k + 15, 0,   1, 8);
        push(0, 0, k + 24, 50,  2, 0);
    endfunction

    int hi_cnt [2] = '{0, 0};

    // Monitor: compare every strobe/done against the head of the queue.
    always @(negedge clk) begin : monitor
        logic [1:0] strobe_v, done_v, ten_v, ply_v;
        int         per_v [2];
        int         stp_v [2];
        exp_t       e;
        strobe_v = {note_strobe_b, note_strobe_a};
        done_v   = {done_b, done_a};
        ten_v    = {tone_en_b, tone_en_a};
        ply_v    = {playing_b, playing_a};
        per_v[0] = int'(tone_period_a);
        per_v[1] = int'(tone_period_b);
        stp_v[0] = int'(step_idx_a);
        stp_v[1] = int'(step_idx_b);
        for (int u = 0; u < 2; u++) begin
            if (strobe_v[u] || done_v[u]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: unit %0d strobe %0b done %0b at cyc %0d, none expected",
                             u, strobe_v[u], done_v[u], cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_unit", u, e.unit);
                    check("ev_kind", done_v[u] ? 1 : 0, e.kind);
                    check("ev_cycle", cyc, e.at);
                    check("ev_tone_hi", hi_cnt[u], e.hi);
                    if (e.kind == 0) begin
                        check("ev_period", per_v[u], e.period);
                        check("ev_step", stp_v[u], e.step);
                    end
                end
                hi_cnt[u] = 0;
            end
            if (!ply_v[u]) hi_cnt[u] = 0;
            else if (ten_v[u]) hi_cnt[u] = hi_cnt[u] + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_pulse(input int unit, output int k);
        @(negedge clk);
        if (unit == 1) start_b = 1'b1;
        else           start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_a_cleared(input string tag);
        check({tag, "_period"}, int'(tone_period_a), 0);
        check({tag, "_tone_en"}, int'(tone_en_a), 0);
        check({tag, "_strobe"}, int'(note_strobe_a), 0);
        check({tag, "_step"}, int'(step_idx_a), 0);
        check({tag, "_playing"}, int'(playing_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_state"}, int'(dbg_a), int'(ST_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        check_a_cleared("reset");
        check("reset_b_playing", int'(playing_b), 0);
        reset = 1'b0;

        // Full melody, no loop: three notes then done, playing falls after.
        start_pulse(0, k);
        push_demo(k);
        push(0, 1, k + 40, 0, 0, 12);
        wait_cyc(k + 41);
        check("end_playing", int'(playing_a), 0);
        check("end_period", int'(tone_period_a), 0);
        wait_cyc(k + 45);

        // Loop: after the end marker step 0 plays again, no done; then stop.
        loop_a = 1'b1;
        start_pulse(0, k);
        push_demo(k);
        push(0, 0, k + 42, 100, 0, 12);
        wait_cyc(k + 44);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        loop_a = 1'b0;
        check_a_cleared("loop_stop");
        wait_cyc(k + 70);

        // Stop in the third cycle of the first note.
        start_pulse(0, k);
        push(0, 0, k + 2, 100, 0, 0);
        wait_cyc(k + 4);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        check_a_cleared("note_stop");
        wait_cyc(k + 30);

        // start and stop together: stop wins.
        @(negedge clk);
        start_a = 1'b1;
        stop_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
        repeat (4) @(negedge clk);
        check("startstop_state", int'(dbg_a), int'(ST_IDLE));
        check("startstop_playing", int'(playing_a), 0);

        // start pulsed during PLAY must not disturb the timeline.
        start_pulse(0, k);
        push_demo(k);
        push(0, 1, k + 40, 0, 0, 12);
        wait_cyc(k + 5);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(k + 41);
        check("restart_ignored_playing", int'(playing_a), 0);
        wait_cyc(k + 45);

        // Reset in the middle of step 2, then a fresh full run.
        start_pulse(0, k);
        push_demo(k);
        wait_cyc(k + 27);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_a_cleared("mid_reset");
        start_pulse(0, k);
        push_demo(k);
        push(0, 1, k + 40, 0, 0, 12);
        wait_cyc(k + 45);

        // Four-step table with no end marker: four notes, done after step 3 gap.
        start_pulse(1, k);
        push(1, 0, k + 2,  10, 0, 0);
        push(1, 0, k + 11, 20, 1, 4);
        push(1, 0, k + 20, 30, 2, 4);
        push(1, 0, k + 29, 40, 3, 4);
        push(1, 1, k + 36, 0,  0, 4);
        wait_cyc(k + 38);
        check("b_end_playing", int'(playing_b), 0);
        check("b_end_step", int'(step_idx_b), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the directed run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
